zeroskip_row_expand_mac64: RTL and testbench

Zero-skip decompressor for the MAC64 row, the inverse of the row encoder. It takes one zero/non-zero (ZNZ) group mask and one compacted 8-entry non-zero vector per group, then scatters the non-zeros back to their dense positions. The dense activations leave as 16-byte beats: one beat per group in 8:16 mode, two beats per group in 8:32 mode. It sits between the encoded-activation store and the dense consumers (write-back, debug readout, golden-model comparison).

---
 rtl/zeroskip_row_expand_mac64.sv | 116 +++++++++++
 tb/tb_zeroskip_row_expand_mac64.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zeroskip_row_expand_mac64.sv
// Zero-skip row decompressor: scatters a compacted non-zero vector back to dense
// positions under a ZNZ group mask and emits it as 16-element beats (8:16 or 8:32).
module zeroskip_row_expand_mac64 #(
    parameter int M              = 8,
    parameter int DATA_W         = 8,
    parameter int DOUT_W         = 16,
    parameter int GROUP_SIZE_MAX = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       group_nz_sel,
    input  logic [GROUP_SIZE_MAX-1:0]  znz_din,
    input  logic                       znz_vld_i,
    output logic                       znz_rdy_o,
    input  logic [M*DATA_W-1:0]        enc_din,
    input  logic                       enc_vld_i,
    output logic                       enc_rdy_o,
    output logic [DOUT_W*DATA_W-1:0]   act_dout,
    output logic                       act_vld_o,
    output logic                       act_last_o,
    input  logic                       act_rdy_i,
    output logic                       err_o
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t                      state, state_nxt;
    logic [GROUP_SIZE_MAX-1:0]   mask_p0;
    logic [M*DATA_W-1:0]         enc_p0;
    logic                        mode_p0;
    logic                        beat_p0;
    logic [GROUP_SIZE_MAX-1:0]   znz_eff;
    logic                        hs;
    logic                        can_load;
    logic                        acc;

    // Number of set mask bits strictly below dense index g (5-bit prefix count).
    function automatic logic [4:0] prefix_count(input logic [GROUP_SIZE_MAX-1:0] m, input int g);
        logic [4:0] c;
        c = '0;
        for (int j = 0; j < GROUP_SIZE_MAX; j++) begin
            if ((j < g) && m[j]) c = c + 5'd1;
        end
        return c;
    endfunction

    function automatic logic [5:0] popcount(input logic [GROUP_SIZE_MAX-1:0] m);
        logic [5:0] c;
        c = '0;
        for (int j = 0; j < GROUP_SIZE_MAX; j++) begin
            if (m[j]) c = c + 6'd1;
        end
        return c;
    endfunction

    // In 8:16 mode only the low beat of the mask is meaningful.
    assign znz_eff = group_nz_sel ? {{(GROUP_SIZE_MAX-DOUT_W){1'b0}}, znz_din[DOUT_W-1:0]}
                                  : znz_din;

    assign act_vld_o  = (state != IDLE);
    assign act_last_o = (state == BEAT1) | ((state == BEAT0) & mode_p0);
    assign hs         = act_vld_o & act_rdy_i;
    assign can_load   = ~rst & ((state == IDLE) | (hs & act_last_o));
    assign acc        = znz_vld_i & enc_vld_i & can_load;
    assign znz_rdy_o  = acc;
    assign enc_rdy_o  = acc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc) state_nxt = BEAT0;
            BEAT0:   if (hs) begin
                         if (!mode_p0) state_nxt = BEAT1;
                         else          state_nxt = acc ? BEAT0 : IDLE;
                     end
            BEAT1:   if (hs) state_nxt = acc ? BEAT0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: latched group (mask, compacted values, mode) and beat index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mask_p0 <= '0;
            enc_p0  <= '0;
            mode_p0 <= 1'b0;
            beat_p0 <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (acc) begin
                mask_p0 <= znz_eff;
                enc_p0  <= enc_din;
                mode_p0 <= group_nz_sel;
                beat_p0 <= 1'b0;
                err_o   <= err_o | (popcount(znz_eff) > 6'(M));
            end else if ((state == BEAT0) && hs && !mode_p0) begin
                beat_p0 <= 1'b1;
            end
        end
    end

    // Scatter: element i takes slot p when its mask bit is set; slots >= M never match.
    always_comb begin
        act_dout = '0;
        for (int i = 0; i < DOUT_W; i++) begin
            for (int k = 0; k < M; k++) begin
                if (mask_p0[int'(beat_p0)*DOUT_W + i] &&
                    (prefix_count(mask_p0, int'(beat_p0)*DOUT_W + i) == 5'(k)))
                    act_dout[i*DATA_W +: DATA_W] = enc_p0[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_zeroskip_row_expand_mac64.sv
// Directed self-checking bench for zeroskip_row_expand_mac64.
module tb_zeroskip_row_expand_mac64;

    logic         clk;
    logic         rst;
    logic         group_nz_sel;
    logic [31:0]  znz_din;
    logic         znz_vld_i;
    logic         znz_rdy_o;
    logic [63:0]  enc_din;
    logic         enc_vld_i;
    logic         enc_rdy_o;
    logic [127:0] act_dout;
    logic         act_vld_o;
    logic         act_last_o;
    logic         act_rdy_i;
    logic         err_o;

    int n_checks = 0;
    int n_fail   = 0;

    zeroskip_row_expand_mac64 dut (
        .clk          (clk),
        .rst          (rst),
        .group_nz_sel (group_nz_sel),
        .znz_din      (znz_din),
        .znz_vld_i    (znz_vld_i),
        .znz_rdy_o    (znz_rdy_o),
        .enc_din      (enc_din),
        .enc_vld_i    (enc_vld_i),
        .enc_rdy_o    (enc_rdy_o),
        .act_dout     (act_dout),
        .act_vld_o    (act_vld_o),
        .act_last_o   (act_last_o),
        .act_rdy_i    (act_rdy_i),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference scatter: walk the dense group, handing out compacted slots in order.
    function automatic logic [255:0] ref_dense(input logic [31:0] m, input logic s, input logic [63:0] e);
        logic [255:0] d;
        int k;
        d = '0;
        k = 0;
        for (int g = 0; g < 32; g++) begin
            if (!(s && g >= 16) && m[g]) begin
                if (k < 8) d[g*8 +: 8] = e[k*8 +: 8];
                k++;
            end
        end
        return d;
    endfunction

    task automatic drive_group(input logic s, input logic [31:0] m, input logic [63:0] e);
        group_nz_sel = s;
        znz_din      = m;
        enc_din      = e;
        znz_vld_i    = 1'b1;
        enc_vld_i    = 1'b1;
    endtask

    task automatic idle_inputs();
        znz_vld_i = 1'b0;
        enc_vld_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        act_rdy_i = 1'b1;
        drive_group(1'b1, 32'h0000_FFFF, 64'h0807_0605_0403_0201);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (act_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", act_vld_o); end
        n_checks++; if (znz_rdy_o !== 1'b0 || enc_rdy_o !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b%b want 00", znz_rdy_o, enc_rdy_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_o); end
        n_checks++; if (act_last_o !== 1'b0 || act_dout !== 128'h0) begin n_fail++; $display("FAIL reset_dout got last=%b %h want 0", act_last_o, act_dout); end
        idle_inputs();
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (znz_rdy_o !== 1'b0 || act_vld_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got rdy=%b vld=%b want 0 0", znz_rdy_o, act_vld_o); end
    endtask

    task automatic test_816_single();
        act_rdy_i = 1'b1;
        drive_group(1'b1, 32'h0000_8001, 64'h0000_0000_0000_2211);
        #1;
        n_checks++; if (znz_rdy_o !== 1'b1 || act_vld_o !== 1'b0) begin n_fail++; $display("FAIL s816_accept got rdy=%b vld=%b want 1 0", znz_rdy_o, act_vld_o); end
        @(posedge clk); #1;
        idle_inputs();
        #1;
        n_checks++; if (act_vld_o !== 1'b1 || act_last_o !== 1'b1) begin n_fail++; $display("FAIL s816_vld_last got %b %b want 1 1", act_vld_o, act_last_o); end
        n_checks++; if (act_dout !== {8'h22, 112'h0, 8'h11}) begin n_fail++; $display("FAIL s816_dout got %h want %h", act_dout, {8'h22, 112'h0, 8'h11}); end
        @(posedge clk); #2;
        n_checks++; if (act_vld_o !== 1'b0) begin n_fail++; $display("FAIL s816_idle got %b want 0", act_vld_o); end
    endtask

    task automatic test_832();
        act_rdy_i = 1'b1;
        drive_group(1'b0, 32'h8000_0101, 64'h0000_0000_0033_2211);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        n_checks++; if (act_dout !== {56'h0, 8'h22, 56'h0, 8'h11} || act_last_o !== 1'b0 || act_vld_o !== 1'b1) begin
            n_fail++; $display("FAIL s832_beat0 got vld=%b last=%b %h want 1 0 %h", act_vld_o, act_last_o, act_dout, {56'h0, 8'h22, 56'h0, 8'h11}); end
        @(posedge clk); #2;
        n_checks++; if (act_dout !== {8'h33, 120'h0} || act_last_o !== 1'b1 || act_vld_o !== 1'b1) begin
            n_fail++; $display("FAIL s832_beat1 got vld=%b last=%b %h want 1 1 %h", act_vld_o, act_last_o, act_dout, {8'h33, 120'h0}); end
        @(posedge clk); #2;
        n_checks++; if (act_vld_o !== 1'b0) begin n_fail++; $display("FAIL s832_idle got %b want 0", act_vld_o); end
    endtask

    task automatic test_backpressure();
        logic [127:0] hold;
        act_rdy_i = 1'b0;
        drive_group(1'b0, 32'h0001_0001, 64'h0000_0000_0000_A2A1);
        #1;
        n_checks++; if (znz_rdy_o !== 1'b1) begin n_fail++; $display("FAIL bp_accept_a got %b want 1", znz_rdy_o); end
        @(posedge clk); #1;
        drive_group(1'b1, 32'h0000_0002, 64'h0000_0000_0000_00B1);
        #1;
        n_checks++; if (act_vld_o !== 1'b1 || act_last_o !== 1'b0 || act_dout !== 128'hA1 || znz_rdy_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_beat0 got vld=%b last=%b rdy=%b %h want 1 0 0 a1", act_vld_o, act_last_o, znz_rdy_o, act_dout); end
        hold = act_dout;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            n_checks++; if (act_dout !== hold || act_vld_o !== 1'b1 || act_last_o !== 1'b0 || znz_rdy_o !== 1'b0 || enc_rdy_o !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d got vld=%b last=%b rdy=%b %h want 1 0 0 %h", c, act_vld_o, act_last_o, znz_rdy_o, act_dout, hold); end
        end
        act_rdy_i = 1'b1;
        #1;
        n_checks++; if (znz_rdy_o !== 1'b0) begin n_fail++; $display("FAIL bp_no_acc_beat0 got %b want 0", znz_rdy_o); end
        @(posedge clk); #2;
        n_checks++; if (act_dout !== 128'hA2 || act_last_o !== 1'b1 || znz_rdy_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_beat1 got last=%b rdy=%b %h want 1 1 a2", act_last_o, znz_rdy_o, act_dout); end
        @(posedge clk); #1;
        idle_inputs();
        #1;
        n_checks++; if (act_vld_o !== 1'b1 || act_last_o !== 1'b1 || act_dout !== {112'h0, 8'hB1, 8'h00}) begin
            n_fail++; $display("FAIL bp_next_group got vld=%b last=%b %h want 1 1 b100", act_vld_o, act_last_o, act_dout); end
        @(posedge clk); #2;
        n_checks++; if (act_vld_o !== 1'b0) begin n_fail++; $display("FAIL bp_idle got %b want 0", act_vld_o); end
    endtask

    task automatic test_overflow();
        act_rdy_i = 1'b1;
        drive_group(1'b1, 32'h0000_03FF, 64'h0807_0605_0403_0201);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        n_checks++; if (act_dout !== {64'h0, 64'h0807_0605_0403_0201}) begin
            n_fail++; $display("FAIL ovf_dout got %h want %h", act_dout, {64'h0, 64'h0807_0605_0403_0201}); end
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %b want 1", err_o); end
        @(posedge clk); #2;
        n_checks++; if (err_o !== 1'b1 || act_vld_o !== 1'b0) begin n_fail++; $display("FAIL ovf_sticky got err=%b vld=%b want 1 0", err_o, act_vld_o); end
    endtask

    task automatic test_back_to_back();
        logic         sels [6];
        logic [31:0]  masks[6];
        logic [63:0]  encs [6];
        logic [127:0] exp_d[8];
        logic         exp_l[8];
        int           acc_cyc[6];
        int           idx, bi, gaps, nb;
        logic [255:0] d;
        sels[0] = 1'b1; masks[0] = 32'h0000_00F0; encs[0] = 64'h0000_0000_0403_0201;
        sels[1] = 1'b1; masks[1] = 32'hFFFF_0005; encs[1] = 64'h0000_0000_0000_BBAA;
        sels[2] = 1'b1; masks[2] = 32'h0000_8421; encs[2] = 64'h0000_0000_4433_2211;
        sels[3] = 1'b1; masks[3] = 32'h0000_FF00; encs[3] = 64'h8877_6655_4433_2211;
        sels[4] = 1'b0; masks[4] = 32'h0001_8000; encs[4] = 64'h0000_0000_0000_9F9E;
        sels[5] = 1'b0; masks[5] = 32'hC000_0003; encs[5] = 64'h0000_0000_D4D3_D2D1;
        nb = 0;
        for (int g = 0; g < 6; g++) begin
            d = ref_dense(masks[g], sels[g], encs[g]);
            for (int b = 0; b < (sels[g] ? 1 : 2); b++) begin
                exp_d[nb] = d[b*128 +: 128];
                exp_l[nb] = sels[g] ? 1'b1 : (b == 1);
                nb++;
            end
        end
        for (int g = 0; g < 6; g++) acc_cyc[g] = -1;
        act_rdy_i = 1'b1;
        idx = 0; bi = 0; gaps = 0;
        for (int cyc = 0; cyc < 40 && !(idx == 6 && bi == 8); cyc++) begin
            if (idx < 6) drive_group(sels[idx], masks[idx], encs[idx]);
            else idle_inputs();
            #1;
            if (act_vld_o) begin
                n_checks++;
                if (bi >= 8) begin
                    n_fail++; $display("FAIL stream_extra_beat got %h want no beat", act_dout);
                end else if (act_dout !== exp_d[bi] || act_last_o !== exp_l[bi]) begin
                    n_fail++; $display("FAIL stream_beat%0d got last=%b %h want last=%b %h", bi, act_last_o, act_dout, exp_l[bi], exp_d[bi]);
                end
                bi++;
            end else if (bi > 0 && bi < 8) begin
                gaps++;
            end
            if (znz_rdy_o && idx < 6) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        n_checks++; if (bi != 8 || idx != 6) begin n_fail++; $display("FAIL stream_timeout got beats=%0d groups=%0d want 8 6", bi, idx); end
        n_checks++; if (gaps != 0) begin n_fail++; $display("FAIL stream_gaps got %0d want 0", gaps); end
        for (int g = 1; g < 6; g++) begin
            n_checks++;
            if (acc_cyc[g] - acc_cyc[g-1] != (g == 5 ? 2 : 1)) begin
                n_fail++; $display("FAIL stream_acc_interval%0d got %0d want %0d", g, acc_cyc[g] - acc_cyc[g-1], (g == 5 ? 2 : 1));
            end
        end
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL stream_err_sticky got %b want 1", err_o); end
    endtask

    task automatic test_reset_mid_group();
        act_rdy_i = 1'b1;
        drive_group(1'b0, 32'h0001_0001, 64'h0000_0000_0000_5A5B);
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (act_vld_o !== 1'b0 || act_last_o !== 1'b0 || err_o !== 1'b0 || act_dout !== 128'h0) begin
            n_fail++; $display("FAIL midreset got vld=%b last=%b err=%b %h want 0 0 0 0", act_vld_o, act_last_o, err_o, act_dout); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (act_vld_o !== 1'b0) begin n_fail++; $display("FAIL midreset_no_beat got %b want 0", act_vld_o); end
    endtask

    initial begin
        rst          = 1'b1;
        act_rdy_i    = 1'b0;
        group_nz_sel = 1'b0;
        znz_din      = '0;
        enc_din      = '0;
        znz_vld_i    = 1'b0;
        enc_vld_i    = 1'b0;
        test_reset();
        test_816_single();
        test_832();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_reset_mid_group();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
